// File: rtl/biriscv_seq_divider_pkg.sv
// Shared definitions for the sequential RV32M divider: instruction decode
// constants, funct3 codes for the divide group, FSM state encoding, step count
// and a small absolute-value helper used when latching operands.
package biriscv_seq_divider_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    // One restoring step per dividend bit
    localparam int unsigned DIV_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Magnitude of a value; only signed operations fold negative inputs
    function automatic logic [31:0] abs_if_signed(input logic is_signed,
                                                  input logic [31:0] value);
        return (is_signed && value[31]) ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/biriscv_seq_divider_div_step.sv
// One combinational restoring-division step: shift the partial remainder left,
// append the next dividend bit, and subtract the divisor when it fits.
// No state; pure function of its inputs.
module biriscv_div_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] divisor,
    input  logic        dividend_bit,
    output logic [31:0] rem_out,
    output logic        quotient_bit
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // The partial remainder stays below the divisor, so the shifted value fits
    // in 33 bits and bit 32 of the difference is an exact borrow flag.
    assign shifted      = {rem_in, dividend_bit};
    assign diff         = shifted - {1'b0, divisor};
    assign quotient_bit = ~diff[32];
    assign rem_out      = diff[32] ? shifted[31:0] : diff[31:0];

endmodule

// File: rtl/biriscv_seq_divider.sv
// Sequential 32-bit RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Fixed latency: result valid in the cycle after the 33rd edge following accept.
// hold_i freezes every register; new ops are only taken when not busy.
module biriscv_seq_divider
    import biriscv_seq_divider_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    output logic        writeback_valid_o,
    output logic [31:0] writeback_value_o,
    output logic        busy_o
);

    div_state_t  state;
    logic [5:0]  step_cnt;
    logic [31:0] dq;          // dividend shifts out MSB-first, quotient shifts in
    logic [31:0] rem;         // partial remainder
    logic [31:0] divisor;     // |divisor|
    logic        q_neg;       // negate quotient at completion
    logic        r_neg;       // negate remainder at completion
    logic        rem_sel;     // REM/REMU selects the remainder
    logic [31:0] result;

    logic [2:0]  funct3;
    logic        is_divgrp;
    logic        accept;
    logic        op_signed;
    logic        op_rem;
    logic [31:0] step_rem;
    logic        step_qbit;

    // Decode: only the divide half of the M extension is handled here
    assign funct3    = opcode_opcode_i[14:12];
    assign is_divgrp = (opcode_opcode_i[6:0] == OPCODE_OP) &&
                       (opcode_opcode_i[31:25] == FUNCT7_MULDIV) && funct3[2];
    assign accept    = opcode_valid_i && !hold_i && (state != ST_RUN) && is_divgrp;
    assign op_signed = (funct3 == FUNCT3_DIV) || (funct3 == FUNCT3_REM);
    assign op_rem    = (funct3 == FUNCT3_REM) || (funct3 == FUNCT3_REMU);

    biriscv_div_step u_step (
        .rem_in       (rem),
        .divisor      (divisor),
        .dividend_bit (dq[31]),
        .rem_out      (step_rem),
        .quotient_bit (step_qbit)
    );

    // Control FSM and datapath: load on accept, 32 steps, sign-correct into DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            step_cnt <= 6'd0;
            dq       <= 32'd0;
            rem      <= 32'd0;
            divisor  <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            rem_sel  <= 1'b0;
            result   <= 32'd0;
        end else if (!hold_i) begin
            case (state)
                ST_RUN: begin
                    if (step_cnt == 6'(DIV_STEPS)) begin
                        // A zero divisor leaves an all-ones quotient and |a| as the
                        // remainder; q_neg was cleared for that case so the
                        // quotient stays all-ones and the remainder becomes a.
                        if (rem_sel)
                            result <= r_neg ? (~rem + 32'd1) : rem;
                        else
                            result <= q_neg ? (~dq + 32'd1) : dq;
                        state <= ST_DONE;
                    end else begin
                        rem      <= step_rem;
                        dq       <= {dq[30:0], step_qbit};
                        step_cnt <= step_cnt + 6'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        dq       <= abs_if_signed(op_signed, opcode_ra_operand_i);
                        divisor  <= abs_if_signed(op_signed, opcode_rb_operand_i);
                        rem      <= 32'd0;
                        step_cnt <= 6'd0;
                        rem_sel  <= op_rem;
                        q_neg    <= op_signed &&
                                    (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31]) &&
                                    (opcode_rb_operand_i != 32'd0);
                        r_neg    <= op_signed && opcode_ra_operand_i[31];
                        state    <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outputs depend on registers only
    assign writeback_valid_o = (state == ST_DONE);
    assign writeback_value_o = (state == ST_DONE) ? result : 32'd0;
    assign busy_o            = (state == ST_RUN);

endmodule

// File: tb/tb_biriscv_seq_divider.sv
// Scoreboard bench for biriscv_seq_divider: driver pushes expected results,
// a negedge monitor pops and compares value and latency on each writeback.
module tb_biriscv_seq_divider;

    logic        clk_i;
    logic        rst_i;
    logic        opcode_valid_i;
    logic [31:0] opcode_opcode_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic        hold_i;
    logic        writeback_valid_o;
    logic [31:0] writeback_value_o;
    logic        busy_o;

    biriscv_seq_divider dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .opcode_valid_i      (opcode_valid_i),
        .opcode_opcode_i     (opcode_opcode_i),
        .opcode_ra_operand_i (opcode_ra_operand_i),
        .opcode_rb_operand_i (opcode_rb_operand_i),
        .hold_i              (hold_i),
        .writeback_valid_o   (writeback_valid_o),
        .writeback_value_o   (writeback_value_o),
        .busy_o              (busy_o)
    );

    typedef struct {
        logic [31:0] val;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   prev_v = 0;

    initial clk_i = 0;
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3,
                                             input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference: RISC-V M-extension division semantics in plain arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        case (f3)
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                sr = sa / sb;
                return sr;
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                sr = sa % sb;
                return sr;
            end
            3'b101:  return (b == 0) ? 32'hFFFFFFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'd0;
            1:       v = 32'hFFFFFFFF;
            2:       v = 32'h80000000;
            3:       v = $urandom_range(0, 20);
            4:       v = 32'd0 - $urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: compare on each rising writeback and keep output invariants
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            prev_v = 0;
        end else begin
            if (writeback_valid_o && !prev_v) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wb: got value %h, required no writeback", writeback_value_o);
                end else begin
                    e = exp_q.pop_front();
                    if (writeback_value_o !== e.val) begin
                        errors++;
                        $display("FAIL wb_value: got %h, required %h", writeback_value_o, e.val);
                    end
                    checks++;
                    if (cyc - e.acc != e.lat) begin
                        errors++;
                        $display("FAIL wb_latency: got %0d, required %0d", cyc - e.acc, e.lat);
                    end
                end
            end
            checks++;
            if (!writeback_valid_o && writeback_value_o !== 32'd0) begin
                errors++;
                $display("FAIL idle_value: got %h, required 0", writeback_value_o);
            end
            checks++;
            if (writeback_valid_o && busy_o) begin
                errors++;
                $display("FAIL busy_and_valid: got busy=1 valid=1, required not both");
            end
            prev_v = writeback_valid_o;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Called at a negedge; leaves at the negedge after the accept edge
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int extra, input bit push);
        int guard = 0;
        while (busy_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        check("issue_not_busy", {31'd0, busy_o}, 32'd0);
        opcode_valid_i      = 1;
        opcode_opcode_i     = mk_instr(7'b0000001, f3, 7'b0110011);
        opcode_ra_operand_i = a;
        opcode_rb_operand_i = b;
        @(posedge clk_i);
        @(negedge clk_i);
        opcode_valid_i = 0;
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        if (push) exp_q.push_back('{ref_model(f3, a, b), 33 + extra, cyc});
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!writeback_valid_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        check("wait_valid_timeout", {31'd0, writeback_valid_o}, 32'd1);
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk_i);
    endtask

    logic [2:0]  d_f3[8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
    logic [31:0] d_a[8]  = '{32'd20, 32'd20, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd7, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] d_b[8]  = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd2, 32'd2,
                             32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};

    initial begin
        logic [31:0] held;
        rst_i = 1;
        opcode_valid_i = 0;
        opcode_opcode_i = 0;
        opcode_ra_operand_i = 0;
        opcode_rb_operand_i = 0;
        hold_i = 0;
        repeat (2) @(negedge clk_i);
        check("reset_valid", {31'd0, writeback_valid_o}, 32'd0);
        check("reset_value", writeback_value_o, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        rst_i = 0;

        // Directed cases; first accept lands on the first edge after reset
        for (int i = 0; i < 8; i++) begin
            issue(d_f3[i], d_a[i], d_b[i], 0, 1);
            wait_drain();
        end

        // MUL encoding and a non-M opcode are ignored in IDLE
        opcode_valid_i  = 1;
        opcode_opcode_i = mk_instr(7'b0000001, 3'b000, 7'b0110011);
        @(negedge clk_i);
        check("mul_ignored", {31'd0, busy_o}, 32'd0);
        opcode_opcode_i = mk_instr(7'b0000000, 3'b100, 7'b0110011);
        @(negedge clk_i);
        check("xor_ignored", {31'd0, busy_o}, 32'd0);
        // A valid divide while stalled is not taken
        hold_i          = 1;
        opcode_opcode_i = mk_instr(7'b0000001, 3'b100, 7'b0110011);
        @(negedge clk_i);
        check("hold_blocks_accept", {31'd0, busy_o}, 32'd0);
        hold_i = 0;
        opcode_valid_i = 0;
        @(negedge clk_i);

        // New op while busy is ignored; only the first result appears
        issue(3'b101, 32'd1000, 32'd3, 0, 1);
        repeat (5) @(negedge clk_i);
        opcode_valid_i      = 1;
        opcode_opcode_i     = mk_instr(7'b0000001, 3'b100, 7'b0110011);
        opcode_ra_operand_i = 32'd55;
        opcode_rb_operand_i = 32'd5;
        @(negedge clk_i);
        opcode_valid_i = 0;
        wait_drain();
        repeat (40) @(negedge clk_i);
        check("busy_op_dropped", {31'd0, busy_o}, 32'd0);

        // Hold for 5 cycles mid-run delays the result by 5
        issue(3'b100, 32'hFFFFFF9C, 32'd7, 5, 1);
        repeat (10) @(negedge clk_i);
        hold_i = 1;
        repeat (5) @(negedge clk_i);
        hold_i = 0;
        wait_drain();

        // Hold while DONE keeps the result presented
        issue(3'b111, 32'd12345, 32'd100, 0, 1);
        wait_valid();
        hold_i = 1;
        held = ref_model(3'b111, 32'd12345, 32'd100);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("done_hold_valid", {31'd0, writeback_valid_o}, 32'd1);
            check("done_hold_value", writeback_value_o, held);
        end
        hold_i = 0;
        @(negedge clk_i);
        check("done_to_idle", {31'd0, writeback_valid_o}, 32'd0);
        wait_drain();

        // Back-to-back: accept during DONE
        issue(3'b100, 32'd99, 32'd9, 0, 1);
        wait_valid();
        check("b2b_old_value", writeback_value_o, 32'd11);
        issue(3'b110, 32'hFFFFFF9D, 32'd10, 0, 1);
        wait_drain();

        // Reset mid-run discards the op
        issue(3'b101, 32'd100, 32'd7, 0, 0);
        repeat (10) @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_valid", {31'd0, writeback_valid_o}, 32'd0);
        check("rst_value", writeback_value_o, 32'd0);
        @(negedge clk_i);
        rst_i = 0;
        repeat (40) @(negedge clk_i);
        check("rst_no_result", {31'd0, busy_o}, 32'd0);
        opcode_valid_i  = 1;
        opcode_opcode_i = mk_instr(7'b0000001, 3'b001, 7'b0110011);
        @(negedge clk_i);
        opcode_valid_i = 0;
        check("rst_mul_ignored", {31'd0, busy_o}, 32'd0);
        issue(3'b101, 32'd100, 32'd7, 0, 1);
        wait_drain();

        // Randomized ops, some issued back-to-back
        for (int n = 0; n < 40; n++) begin
            logic [2:0] f3;
            f3 = 3'b100 | 3'($urandom_range(0, 3));
            issue(f3, pick_operand(), pick_operand(), 0, 1);
            if ($urandom_range(0, 2) == 0) begin
                wait_valid();
            end else begin
                wait_drain();
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
            end
        end
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biriscv_seq_divider.md
BIRISCV_SEQ_DIVIDER -- requirements
Module: biriscv_seq_divider

Interface
REQ-001 SHALL have no parameters; operand width fixed at 32 bits.
REQ-002 SHALL have ports, in this order:
  clk_i  input  1  single clock; all state updates on its rising edge.
  rst_i  input  1  reset, asynchronous and active-high.
  opcode_valid_i  input  1  instruction presented this cycle.
  opcode_opcode_i  input  32  instruction word; funct7 [31:25], funct3 [14:12], opcode [6:0] decoded.
  opcode_ra_operand_i  input  32  rs1 value (dividend).
  opcode_rb_operand_i  input  32  rs2 value (divisor).
  hold_i  input  1  pipeline stall; freezes the block.
  writeback_valid_o  output  1  result valid.
  writeback_value_o  output  32  quotient or remainder.
  busy_o  output  1  operation in progress; no new op accepted.

Function
REQ-003 SHALL accept an op only when opcode_valid_i=1, hold_i=0, state IDLE or DONE, opcode=0110011, funct7=0000001 and funct3[2]=1; DIV=100, DIVU=101, REM=110, REMU=111.
REQ-004 SHALL ignore MUL-group funct3 (0xx), non-matching encodings, and any opcode_valid_i while busy_o=1, with no state change.
REQ-005 SHALL implement states IDLE, RUN, DONE: IDLE/DONE -accept-> RUN; RUN -(32 steps complete)-> DONE; DONE -(hold_i=0, no accept)-> IDLE.
REQ-006 On accept SHALL latch signed-op flag, remainder-select flag, |dividend|, |divisor|, quotient sign (sign(a) xor sign(b)) and remainder sign (sign(a)); signed ops only take absolute values.
REQ-007 In RUN SHALL perform one restoring step per unstalled cycle: shift partial remainder left 1, bring in next dividend bit (MSB first), subtract divisor if no borrow, set quotient bit; 6-bit step counter from 0 to 31.
REQ-008 SHALL apply sign correction to quotient/remainder (two's complement negate) when entering DONE.
REQ-009 Divisor zero: quotient 0xFFFFFFFF (all ops), remainder = original dividend; same latency.
REQ-010 Signed overflow (DIV/REM, a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0; same latency.
REQ-011 Latency SHALL be fixed: with hold_i=0, writeback_valid_o rises in the cycle after the 33rd rising edge following the accept edge.
REQ-012 writeback_valid_o SHALL be high exactly while state is DONE; writeback_value_o SHALL be stable throughout DONE and 0 otherwise.
REQ-013 hold_i=1 SHALL freeze state, counter and datapath in every state; DONE persists until hold_i=0.
REQ-014 Accept in DONE (back-to-back) SHALL present the old result for that cycle and enter RUN next edge.
REQ-015 busy_o SHALL be 1 in RUN, 0 in IDLE and DONE.

Reset
REQ-016 rst_i=1 SHALL immediately force state IDLE, counter 0, all datapath registers 0, writeback_valid_o=0, writeback_value_o=0, busy_o=0, independent of clk_i.
REQ-017 Reset asserted mid-RUN SHALL discard the operation; no result is produced after release.
REQ-018 First accept SHALL be possible on the first rising edge after rst_i deasserts.

Structure
REQ-019 Shared package SHALL hold: opcode/funct7 constants, DIV/DIVU/REM/REMU funct3 localparams, state encoding (IDLE, RUN, DONE), step count 32.
REQ-020 SHALL contain one sub-module, biriscv_div_step: combinational single restoring step (remainder in, divisor, dividend bit in -> remainder out, quotient bit).
REQ-021 SHALL contain no combinational path from any input to writeback_value_o or writeback_valid_o.

Verification
REQ-022 DIV a=20, b=0xFFFFFFFD (-3) -> value 0xFFFFFFFA (-6) after exactly 33 cycles; REM same operands -> 0x00000002.
REQ-023 DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; REMU same -> 0x00000001.
REQ-024 DIV a=7, b=0 -> 0xFFFFFFFF; REM a=7, b=0 -> 0x00000007; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-025 hold_i=1 for 5 cycles mid-RUN -> result appears 5 cycles late, value unchanged; hold_i=1 in DONE -> writeback_valid_o stays high.
REQ-026 rst_i pulse at step 10 of DIVU 100/7 -> outputs 0 immediately, no writeback_valid_o; next MUL encoding ignored; subsequent DIVU 100/7 -> 0x0000000E.
